// File: rtl/nioslab2_memtest_pkg.sv
// Shared types and default sizing for the memory-test master.
package nioslab2_memtest_pkg;

  localparam int unsigned ADDR_W_DEF    = 15;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned MAX_WORDS_DEF = 32000;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : CNT_W'(v + CNT_W'(1));
  endfunction

endpackage

// File: rtl/nioslab2_memtest_pattern.sv
// Address and data pattern for a word index: base + i and seed + i (both wrap).
module nioslab2_memtest_pattern
  import nioslab2_memtest_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [CNT_W-1:0]  idx_i,
  output logic [ADDR_W-1:0] addr_c_o,
  output logic [DATA_W-1:0] data_c_o
);

  assign addr_c_o = ADDR_W'(base_i + ADDR_W'(idx_i));
  assign data_c_o = DATA_W'(seed_i + DATA_W'(idx_i));

endmodule

// File: rtl/nioslab2_memtest_master.sv
// Avalon-MM memory test master: fills a window with seed+i, optionally reads it
// back and counts mismatches. Command strobes and status are all registered.
module nioslab2_memtest_master
  import nioslab2_memtest_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_WORDS    = MAX_WORDS_DEF,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              check_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  // Range check is done one bit wider than either operand so it cannot wrap.
  localparam int unsigned CHK_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;
  // READ_LATENCY must be at least 1; the counter holds the remaining wait cycles.
  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic                check_q, check_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                cs_q, cs_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_q, first_d;

  logic [CNT_W-1:0]    idx_inc_c;
  logic                last_c;
  logic                range_bad_c;
  logic                rd_mismatch_c;
  logic [ADDR_W-1:0]   nxt_addr_c, cur_addr_c;
  logic [DATA_W-1:0]   nxt_data_c, cur_data_c;

  assign idx_inc_c     = CNT_W'(idx_q + CNT_W'(1));
  assign last_c        = (idx_q == CNT_W'(num_q - CNT_W'(1)));
  assign range_bad_c   = (CHK_W'(base_addr) + CHK_W'(num_words)) > CHK_W'(MAX_WORDS);
  assign rd_mismatch_c = (avm_readdata != cur_data_c);

  // Pattern for the next index to issue (index 0 is simply base/seed).
  nioslab2_memtest_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pat_nxt (
    .base_i   (base_q),
    .seed_i   (seed_q),
    .idx_i    (idx_inc_c),
    .addr_c_o (nxt_addr_c),
    .data_c_o (nxt_data_c)
  );

  // Pattern for the index currently being read back.
  nioslab2_memtest_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pat_cur (
    .base_i   (base_q),
    .seed_i   (seed_q),
    .idx_i    (idx_q),
    .addr_c_o (cur_addr_c),
    .data_c_o (cur_data_c)
  );

  // Next-state and next-output logic; strobes change together with the state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    check_d   = check_q;
    base_d    = base_q;
    seed_d    = seed_q;
    lat_d     = lat_q;
    cs_d      = cs_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;

    unique case (state_q)
      IDLE: begin
        cs_d = 1'b0;
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (start) begin
          check_d   = check_en;
          base_d    = base_addr;
          num_d     = num_words;
          seed_d    = seed;
          idx_d     = '0;
          error_d   = 1'b0;
          err_cnt_d = '0;
          first_d   = '0;
          if (range_bad_c) begin
            state_d = DONE;
            error_d = 1'b1;
            done_d  = 1'b1;
          end else if (num_words == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WRITE;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = base_addr;
            wdata_d = seed;
          end
        end
      end

      WRITE: begin
        if (!avm_waitrequest) begin
          if (abort || (last_c && !check_q)) begin
            state_d = DONE;
            cs_d    = 1'b0;
            wr_d    = 1'b0;
            done_d  = 1'b1;
            if (abort) error_d = 1'b1;
          end else if (last_c) begin
            state_d = READ;
            idx_d   = '0;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
            addr_d  = base_q;
          end else begin
            idx_d   = idx_inc_c;
            addr_d  = nxt_addr_c;
            wdata_d = nxt_data_c;
          end
        end
      end

      READ: begin
        if (!avm_waitrequest) begin
          state_d = RD_WAIT;
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          lat_d   = LAT_LOAD;
        end
      end

      RD_WAIT: begin
        if (lat_q != '0) begin
          lat_d = LAT_W'(lat_q - LAT_W'(1));
        end else begin
          if (rd_mismatch_c) begin
            error_d   = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            if (err_cnt_q == '0) first_d = cur_addr_c;
          end
          if (abort || last_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            if (abort) error_d = 1'b1;
          end else begin
            state_d = READ;
            idx_d   = idx_inc_c;
            cs_d    = 1'b1;
            rd_d    = 1'b1;
            addr_d  = nxt_addr_c;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any transfer silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      check_q   <= 1'b0;
      base_q    <= '0;
      seed_q    <= '0;
      lat_q     <= '0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      check_q   <= check_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      lat_q     <= lat_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_count      = err_cnt_q;
  assign first_err_addr = first_q;

endmodule
